toy_phy_reg_freelist: RTL and testbench

TOY_PHY_REG_FREELIST -- requirements
Module: toy_phy_reg_freelist

---
 rtl/toy_pack.sv | 10 +
 rtl/toy_freelist_compact.sv | 26 ++
 rtl/toy_phy_reg_freelist.sv | 134 +++++++++++++
 tb/tb_toy_phy_reg_freelist.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_pack.sv
// Shared rename-stage sizing for the toy core: physical register ID width and
// decode/commit slot counts.
package toy_pack;

    localparam int PHY_REG_NUM_DEFAULT = 128;
    localparam int PHY_REG_ID_WIDTH    = $clog2(PHY_REG_NUM_DEFAULT);
    localparam int INST_DECODE_NUM     = 4;
    localparam int INST_COMMIT_NUM     = 4;

endpackage

// File: rtl/toy_freelist_compact.sv
// Prefix-popcount offset generator: each valid slot gets its rank among the
// valid slots below it, so sparse requests map onto consecutive list entries.
module toy_freelist_compact
    import toy_pack::*;
#(
    parameter int N  = INST_DECODE_NUM,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         valid,
    output logic [N-1:0][CW-1:0] offset,
    output logic [CW-1:0]        total
);

    // NOTE: acc is a running sum, so blocking assignments are intended here;
    // every output is assigned on every path, so no latch is inferred.
    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            offset[i] = acc;
            acc       = acc + CW'(valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/toy_phy_reg_freelist.sv
// Physical register free list: circular buffer with speculative/architectural
// heads for flush recovery. Optional stall counter under TOY_FREELIST_PERF_EN.
module toy_phy_reg_freelist
    import toy_pack::*;
#(
    parameter int PHY_REG_NUM  = 128,
    parameter int ARCH_REG_NUM = 32
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [INST_DECODE_NUM-1:0]                       alloc_req,
    output logic                                             alloc_ready,
    output logic [INST_DECODE_NUM-1:0][PHY_REG_ID_WIDTH-1:0] alloc_id,
    input  logic [INST_COMMIT_NUM-1:0]                       release_en,
    input  logic [INST_COMMIT_NUM-1:0][PHY_REG_ID_WIDTH-1:0] release_id,
    input  logic [2:0]                                       commit_alloc_cnt,
    input  logic                                             cancel_edge_en,
    output logic [PHY_REG_ID_WIDTH:0]                        free_cnt
`ifdef TOY_FREELIST_PERF_EN
    ,
    output logic [31:0]                                      alloc_stall_cnt
`endif
);

    localparam int PW    = PHY_REG_ID_WIDTH + 1;
    localparam int AVAIL = PHY_REG_NUM - ARCH_REG_NUM;
    localparam int ACW   = $clog2(INST_DECODE_NUM + 1);
    localparam int RCW   = $clog2(INST_COMMIT_NUM + 1);

    typedef logic [PW-1:0]               ptr_t;
    typedef logic [PHY_REG_ID_WIDTH-1:0] id_t;
    typedef logic [PW:0]                 sum_t;

    ptr_t spec_head;
    ptr_t arch_head;
    ptr_t tail;
    id_t  entry [PHY_REG_NUM];

    logic [INST_DECODE_NUM-1:0][ACW-1:0] alloc_off;
    logic [ACW-1:0]                      alloc_total;
    logic [INST_COMMIT_NUM-1:0][RCW-1:0] rel_off;
    logic [RCW-1:0]                      rel_total;

    id_t  rd_idx [INST_DECODE_NUM];
    id_t  wr_idx [INST_COMMIT_NUM];
    ptr_t arch_next;
    logic alloc_fire;

    toy_freelist_compact #(
        .N (INST_DECODE_NUM),
        .CW(ACW)
    ) u_alloc_compact (
        .valid (alloc_req),
        .offset(alloc_off),
        .total (alloc_total)
    );

    toy_freelist_compact #(
        .N (INST_COMMIT_NUM),
        .CW(RCW)
    ) u_release_compact (
        .valid (release_en),
        .offset(rel_off),
        .total (rel_total)
    );

    assign free_cnt  = tail - spec_head;
    assign arch_next = arch_head + ptr_t'(commit_alloc_cnt);

    // A zero-slot request is always ready; otherwise the whole group must fit
    // and a flush blocks the grant.
    assign alloc_ready = (alloc_total == '0) ||
                         ((ptr_t'(alloc_total) <= free_cnt) && !cancel_edge_en);
    assign alloc_fire  = alloc_ready && !cancel_edge_en;

    always_comb begin
        for (int i = 0; i < INST_DECODE_NUM; i++) begin
            rd_idx[i]   = spec_head[PHY_REG_ID_WIDTH-1:0] + id_t'(alloc_off[i]);
            alloc_id[i] = entry[rd_idx[i]];
        end
        for (int j = 0; j < INST_COMMIT_NUM; j++) begin
            wr_idx[j] = tail[PHY_REG_ID_WIDTH-1:0] + id_t'(rel_off[j]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_head <= '0;
            arch_head <= '0;
            tail      <= ptr_t'(AVAIL);
        end else begin
            arch_head <= arch_next;
            tail      <= tail + ptr_t'(rel_total);
            if (cancel_edge_en) begin
                spec_head <= arch_next;
            end else if (alloc_fire) begin
                spec_head <= spec_head + ptr_t'(alloc_total);
            end
        end
    end

    // NOTE: the list contents are architecturally visible after reset (the
    // initial free IDs), so the storage must be reset, not left uninitialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PHY_REG_NUM; k++) begin
                entry[k] <= (k < AVAIL) ? id_t'(ARCH_REG_NUM + k) : '0;
            end
        end else begin
            for (int j = 0; j < INST_COMMIT_NUM; j++) begin
                if (release_en[j]) begin
                    entry[wr_idx[j]] <= release_id[j];
                end
            end
        end
    end

`ifdef TOY_FREELIST_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_stall_cnt <= '0;
        end else if ((|alloc_req) && !alloc_ready && (alloc_stall_cnt != '1)) begin
            alloc_stall_cnt <= alloc_stall_cnt + 32'd1;
        end
    end
`endif

    // Releasing more IDs than the list can ever hold corrupts live entries.
    a_no_release_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        (sum_t'(free_cnt) + sum_t'(rel_total)) <= sum_t'(AVAIL)
    );

endmodule

// File: tb/tb_toy_phy_reg_freelist.sv
// Self-checking bench for toy_phy_reg_freelist: directed vector table, corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_toy_phy_reg_freelist;
    import toy_pack::*;

    localparam int W     = PHY_REG_ID_WIDTH;
    localparam int AVAIL = 96;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           alloc_req;
    logic                 alloc_ready;
    logic [3:0][W-1:0]    alloc_id;
    logic [3:0]           release_en;
    logic [3:0][W-1:0]    release_id;
    logic [2:0]           commit_alloc_cnt;
    logic                 cancel_edge_en;
    logic [W:0]           free_cnt;
`ifdef TOY_FREELIST_PERF_EN
    logic [31:0]          alloc_stall_cnt;
    int                   m_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    toy_phy_reg_freelist #(
        .PHY_REG_NUM (128),
        .ARCH_REG_NUM(32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_req       (alloc_req),
        .alloc_ready     (alloc_ready),
        .alloc_id        (alloc_id),
        .release_en      (release_en),
        .release_id      (release_id),
        .commit_alloc_cnt(commit_alloc_cnt),
        .cancel_edge_en  (cancel_edge_en),
        .free_cnt        (free_cnt)
`ifdef TOY_FREELIST_PERF_EN
        ,
        .alloc_stall_cnt (alloc_stall_cnt)
`endif
    );

    typedef struct {
        bit              rst;
        logic [3:0]      req;
        logic [2:0]      cnt;
        bit              cancel;
        bit              exp_ready;
        int              exp_free;
        logic [3:0][W-1:0] exp_id;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] ren,
                         input logic [3:0][W-1:0] rid, input logic [2:0] cnt,
                         input logic cancel);
        alloc_req        = req;
        release_en       = ren;
        release_id       = rid;
        commit_alloc_cnt = cnt;
        cancel_edge_en   = cancel;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'b0, 4'b0, '0, 3'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(bit rst, logic [3:0] req, logic [2:0] cnt, bit cancel,
                                bit r, int f, int i3, int i2, int i1, int i0);
        vec_t v;
        v.rst       = rst;
        v.req       = req;
        v.cnt       = cnt;
        v.cancel    = cancel;
        v.exp_ready = r;
        v.exp_free  = f;
        v.exp_id    = {W'(i3), W'(i2), W'(i1), W'(i0)};
        return v;
    endfunction

    // Reference model: ids from arch head to tail in FIFO order; the first
    // spec_off of them are speculatively allocated.
    int fl[$];
    int spec_off;

    task automatic model_reset();
        fl.delete();
        for (int k = 0; k < AVAIL; k++) fl.push_back(32 + k);
        spec_off = 0;
`ifdef TOY_FREELIST_PERF_EN
        m_stall = 0;
`endif
    endtask

    initial begin
        rst_n = 1'b1;
        drive(4'b0, 4'b0, '0, 3'd0, 1'b0);
        @(negedge clk);
        do_reset();

        check("rst_free", 32'(free_cnt), 96);
        check("rst_ready", 32'(alloc_ready), 1);
        check("rst_id0", 32'(alloc_id[0]), 32);
        check("rst_id3", 32'(alloc_id[3]), 32);
`ifdef TOY_FREELIST_PERF_EN
        check("rst_stall", alloc_stall_cnt, 0);
`endif

        tbl[0]  = mk(1, 4'b1111, 0, 0, 1, 96, 35, 34, 33, 32);
        tbl[1]  = mk(0, 4'b0000, 0, 0, 1, 92, 36, 36, 36, 36);
        tbl[2]  = mk(1, 4'b1010, 0, 0, 1, 96, 33, 33, 32, 32);
        tbl[3]  = mk(0, 4'b0000, 0, 0, 1, 94, 34, 34, 34, 34);
        tbl[4]  = mk(0, 4'b0110, 0, 0, 1, 94, 36, 35, 34, 34);
        tbl[5]  = mk(0, 4'b0000, 0, 0, 1, 92, 36, 36, 36, 36);
        tbl[6]  = mk(1, 4'b1111, 0, 0, 1, 96, 35, 34, 33, 32);
        tbl[7]  = mk(0, 4'b1111, 0, 0, 1, 92, 39, 38, 37, 36);
        tbl[8]  = mk(0, 4'b0001, 3, 1, 0, 88, 41, 41, 41, 40);
        tbl[9]  = mk(0, 4'b0000, 0, 0, 1, 93, 35, 35, 35, 35);
        tbl[10] = mk(0, 4'b1111, 0, 0, 1, 93, 38, 37, 36, 35);
        tbl[11] = mk(0, 4'b0000, 4, 0, 1, 89, 39, 39, 39, 39);
        tbl[12] = mk(0, 4'b0000, 0, 1, 1, 89, 39, 39, 39, 39);
        tbl[13] = mk(0, 4'b0000, 0, 0, 1, 89, 39, 39, 39, 39);

        for (int v = 0; v < 14; v++) begin
            if (tbl[v].rst) do_reset();
            drive(tbl[v].req, 4'b0, '0, tbl[v].cnt, tbl[v].cancel);
            check($sformatf("tbl%0d_ready", v), 32'(alloc_ready), 32'(tbl[v].exp_ready));
            check($sformatf("tbl%0d_free", v), 32'(free_cnt), tbl[v].exp_free);
            for (int i = 0; i < 4; i++)
                check($sformatf("tbl%0d_id%0d", v, i), 32'(alloc_id[i]), 32'(tbl[v].exp_id[i]));
            step();
        end

        // Drain to two free entries, then an oversize and an exact-fit request.
        do_reset();
        for (int c = 0; c < 23; c++) begin
            drive(4'b1111, 4'b0, '0, 3'd0, 1'b0);
            check("drain_ready", 32'(alloc_ready), 1);
            step();
        end
        drive(4'b0011, 4'b0, '0, 3'd0, 1'b0);
        step();
        drive(4'b0111, 4'b0, '0, 3'd0, 1'b0);
        check("over_ready", 32'(alloc_ready), 0);
        check("over_free", 32'(free_cnt), 2);
        step();
        drive(4'b0000, 4'b0, '0, 3'd0, 1'b0);
        check("over_hold_free", 32'(free_cnt), 2);
        check("over_hold_id0", 32'(alloc_id[0]), 126);
        drive(4'b0011, 4'b0, '0, 3'd0, 1'b0);
        check("fit_ready", 32'(alloc_ready), 1);
        check("fit_id0", 32'(alloc_id[0]), 126);
        check("fit_id1", 32'(alloc_id[1]), 127);
        step();
        drive(4'b0000, 4'b0, '0, 3'd0, 1'b0);
        check("empty_free", 32'(free_cnt), 0);
        check("empty_zero_ready", 32'(alloc_ready), 1);
        drive(4'b0001, 4'b0, '0, 3'd0, 1'b0);
        check("empty_one_ready", 32'(alloc_ready), 0);

        // Release into an empty list: not allocatable until the next cycle.
        do_reset();
        for (int c = 0; c < 24; c++) begin
            drive(4'b1111, 4'b0, '0, 3'd0, 1'b0);
            step();
        end
        drive(4'b0001, 4'b0101, {W'(0), W'(41), W'(0), W'(40)}, 3'd0, 1'b0);
        check("rel_same_ready", 32'(alloc_ready), 0);
        check("rel_same_free", 32'(free_cnt), 0);
        step();
        drive(4'b0011, 4'b0, '0, 3'd0, 1'b0);
        check("rel_next_ready", 32'(alloc_ready), 1);
        check("rel_next_free", 32'(free_cnt), 2);
        check("rel_next_id0", 32'(alloc_id[0]), 40);
        check("rel_next_id1", 32'(alloc_id[1]), 41);
        step();
        drive(4'b0000, 4'b0, '0, 3'd0, 1'b0);
        check("rel_after_free", 32'(free_cnt), 0);

        // Randomized traffic; pointers wrap many times over this run.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [3:0]        req;
            logic [3:0]        ren;
            logic [3:0][W-1:0] rid;
            int                cnt, room, maxrel, n, free, k;
            bit                cancel, exp_ready;

            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                model_reset();
            end
            cnt    = $urandom_range(0, (spec_off < 4) ? spec_off : 4);
            cancel = ($urandom_range(0, 15) == 0);
            req    = 4'($urandom);
            room   = AVAIL - fl.size();
            maxrel = (room < 4) ? room : 4;
            ren    = 4'($urandom);
            for (int b = 3; b >= 0; b--)
                if ($countones(ren) > maxrel) ren[b] = 1'b0;
            for (int j = 0; j < 4; j++) rid[j] = W'($urandom);

            drive(req, ren, rid, 3'(cnt), cancel);
            n         = $countones(req);
            free      = fl.size() - spec_off;
            exp_ready = (n == 0) || ((n <= free) && !cancel);
            check("rnd_ready", 32'(alloc_ready), 32'(exp_ready));
            check("rnd_free", 32'(free_cnt), free);
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (spec_off + k < fl.size())
                    check($sformatf("rnd_id%0d", i), 32'(alloc_id[i]), fl[spec_off + k]);
                if (req[i]) k++;
            end
`ifdef TOY_FREELIST_PERF_EN
            check("rnd_stall", alloc_stall_cnt, m_stall);
            if ((n != 0) && !exp_ready) m_stall++;
`endif
            @(posedge clk);
            if (exp_ready && !cancel) spec_off += n;
            for (int c = 0; c < cnt; c++) void'(fl.pop_front());
            spec_off -= cnt;
            if (cancel) spec_off = 0;
            for (int j = 0; j < 4; j++)
                if (ren[j]) fl.push_back(int'(rid[j]));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
